mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch port (IF, read-only) and the data-memory port (DM, load/store) of riscv_core.
- Sits between the IF/MEM pipeline stages and the memory model.
- Allows one outstanding transaction at a time.
- The pipeline stalls on a requester's ready/rvalid; those stalls interact with load-use stall logic, so arbitration must be deterministic.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 62 ++++++
 rtl/mem_arbiter_pick.sv | 50 +++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared types and widths for the IF/DM unified-memory arbiter.
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Bundle of fetch port, data port, memory port and error flag.
//           slave  = arbiter view, master = requesters/memory view.
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = mem_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_arbiter_pkg::DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  // instruction fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  // data memory port
  logic                  dm_req;
  logic                  dm_we;
  logic [BE_WIDTH-1:0]   dm_be;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ready;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  // unified memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // status
  logic                  err_spurious;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_ready, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output err_spurious
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_ready, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  err_spurious
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pick
// Brief   : Combinational requester selection. A selection already presented
//           to memory is kept until granted; otherwise DM beats IF, or with
//           round-robin the pointer decides collisions.
// Config  : MEM_ARB_RR_EN - round-robin collision resolution
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       if_req_i,
  input  logic       dm_req_i,
  input  arb_owner_e ptr_i,
  input  arb_owner_e held_i,
  output arb_owner_e pick_o
);

  logic w_both;
  assign w_both = if_req_i && dm_req_i;

`ifndef MEM_ARB_RR_EN
  // pointer only matters for round-robin builds
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr_i;
`endif

  // held selection first, then collision resolution, then lone requester
  always_comb begin
    pick_o = OWN_NONE;
    if (held_i == OWN_IF && if_req_i) begin
      pick_o = OWN_IF;
    end else if (held_i == OWN_DM && dm_req_i) begin
      pick_o = OWN_DM;
    end else if (w_both) begin
`ifdef MEM_ARB_RR_EN
      pick_o = (ptr_i == OWN_IF) ? OWN_IF : OWN_DM;
`else
      pick_o = OWN_DM;
`endif
    end else if (dm_req_i) begin
      pick_o = OWN_DM;
    end else if (if_req_i) begin
      pick_o = OWN_IF;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares one single-port memory between the fetch (IF) and data
//           (DM) ports, one outstanding transaction at a time.
// Config  : MEM_ARB_RR_EN - round-robin instead of fixed DM>IF priority
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;   // owner of the outstanding transaction
  arb_owner_e sel_q,   sel_d;     // presented-but-not-granted selection
  arb_owner_e ptr_q,   ptr_d;     // round-robin preference
  logic       we_q,    we_d;      // outstanding transaction is a store
  logic       err_q,   err_d;

  arb_owner_e w_pick;

  mem_arb_pick u_pick (
    .if_req_i (bus.if_req),
    .dm_req_i (bus.dm_req),
    .ptr_i    (ptr_q),
    .held_i   (sel_q),
    .pick_o   (w_pick)
  );

  // state and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      sel_q   <= OWN_NONE;
      ptr_q   <= OWN_DM;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // next state and all port outputs; outputs are forced low while in reset
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    err_d   = err_q;

    bus.if_ready  = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_ready  = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.dm_rdata  = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    if (!rst) begin
      unique case (state_q)
        ARB_IDLE: begin
          // a response with nothing outstanding is flagged and dropped
          if (bus.mem_rvalid) begin
            err_d = 1'b1;
          end
          sel_d = OWN_NONE;

          if (w_pick == OWN_IF) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = bus.if_addr;
          end else if (w_pick == OWN_DM) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = bus.dm_we;
            bus.mem_addr  = bus.dm_addr;
            bus.mem_be    = bus.dm_we ? bus.dm_be : '1;
            bus.mem_wdata = bus.dm_we ? bus.dm_wdata : '0;
          end

          if (w_pick != OWN_NONE) begin
            if (bus.mem_gnt) begin
              bus.if_ready = (w_pick == OWN_IF);
              bus.dm_ready = (w_pick == OWN_DM);
              state_d      = ARB_WAIT;
              owner_d      = w_pick;
              we_d         = (w_pick == OWN_DM) && bus.dm_we;
`ifdef MEM_ARB_RR_EN
              ptr_d        = (w_pick == OWN_DM) ? OWN_IF : OWN_DM;
`endif
            end else begin
              sel_d = w_pick;
            end
          end
        end

        ARB_WAIT: begin
          if (bus.mem_rvalid) begin
            if (owner_q == OWN_IF) begin
              bus.if_rvalid = 1'b1;
              bus.if_rdata  = bus.mem_rdata;
            end else if (owner_q == OWN_DM) begin
              bus.dm_rvalid = 1'b1;
              bus.dm_rdata  = we_q ? '0 : bus.mem_rdata;
            end
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
            we_d    = 1'b0;
          end
        end

        default: begin
          state_d = ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.err_spurious = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter (default build).
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge, then let inputs be changed away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},  {31'd0, bus.mem_req},   32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr,           32'd0);
    check({tag, "_if_ready"}, {31'd0, bus.if_ready},  32'd0);
    check({tag, "_dm_ready"}, {31'd0, bus.dm_ready},  32'd0);
    check({tag, "_if_rv"},    {31'd0, bus.if_rvalid}, 32'd0);
    check({tag, "_dm_rv"},    {31'd0, bus.dm_rvalid}, 32'd0);
    check({tag, "_err"},      {31'd0, bus.err_spurious}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    // reset with a request already pending: outputs must stay low
    bus.if_req = 1;
    #12;
    check_all_zero("reset");
    bus.if_req = 0;
    rst = 0;
    step();

    // ---------------- IF alone ----------------
    bus.if_req = 1; bus.if_addr = 32'h0; bus.mem_gnt = 1;
    settle();
    check("if_mem_req",  {31'd0, bus.mem_req},  32'd1);
    check("if_ready",    {31'd0, bus.if_ready}, 32'd1);
    check("if_mem_we",   {31'd0, bus.mem_we},   32'd0);
    check("if_mem_be",   {28'd0, bus.mem_be},   32'd0);
    step();
    bus.if_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h00500093;
    settle();
    check("if_rvalid",   {31'd0, bus.if_rvalid}, 32'd1);
    check("if_rdata",    bus.if_rdata,           32'h00500093);
    check("if_wait_req", {31'd0, bus.mem_req},   32'd0);
    check("if_wait_rdy", {31'd0, bus.if_ready},  32'd0);
    step();
    bus.mem_rvalid = 0;
    settle();
    check("if_rv_after", {31'd0, bus.if_rvalid}, 32'd0);
    check("if_rd_after", bus.if_rdata,           32'd0);

    // ---------------- simultaneous IF + DM load ----------------
    bus.if_req = 1; bus.if_addr = 32'h4;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h1000; bus.dm_be = 4'h0;
    bus.mem_gnt = 1;
    settle();
    check("col_dm_ready", {31'd0, bus.dm_ready}, 32'd1);
    check("col_if_ready", {31'd0, bus.if_ready}, 32'd0);
    check("col_addr",     bus.mem_addr,          32'h1000);
    check("col_be",       {28'd0, bus.mem_be},   32'hF);
    check("col_we",       {31'd0, bus.mem_we},   32'd0);
    step();
    bus.dm_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'd50;
    settle();
    check("col_dm_rv",    {31'd0, bus.dm_rvalid}, 32'd1);
    check("col_dm_rdata", bus.dm_rdata,           32'd50);
    check("col_if_rv",    {31'd0, bus.if_rvalid}, 32'd0);
    check("col_if_rdy_w", {31'd0, bus.if_ready},  32'd0);
    step();
    bus.mem_rvalid = 0; bus.mem_gnt = 1;
    settle();
    check("col_if_grant", {31'd0, bus.if_ready}, 32'd1);
    check("col_if_addr",  bus.mem_addr,          32'h4);
    step();
    bus.if_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h00000013;
    settle();
    check("col_if_rdata", bus.if_rdata, 32'h00000013);
    check("col_dm_rd0",   bus.dm_rdata, 32'd0);
    step();
    bus.mem_rvalid = 0;

    // ---------------- store with grant wait states ----------------
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_be = 4'hF; bus.dm_addr = 32'h1000;
    bus.dm_wdata = 32'd50; bus.mem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.if_req = 1; bus.if_addr = 32'h8;
      end
      settle();
      check("ws_req",   {31'd0, bus.mem_req},  32'd1);
      check("ws_addr",  bus.mem_addr,          32'h1000);
      check("ws_wdata", bus.mem_wdata,         32'd50);
      check("ws_we",    {31'd0, bus.mem_we},   32'd1);
      check("ws_be",    {28'd0, bus.mem_be},   32'hF);
      check("ws_rdy",   {31'd0, bus.dm_ready}, 32'd0);
      step();
    end
    bus.mem_gnt = 1;
    settle();
    check("ws_addr4",    bus.mem_addr,          32'h1000);
    check("ws_dm_ready", {31'd0, bus.dm_ready}, 32'd1);
    check("ws_if_ready", {31'd0, bus.if_ready}, 32'd0);
    step();
    bus.dm_req = 0; bus.dm_we = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD;
    settle();
    check("ws_dm_rv",    {31'd0, bus.dm_rvalid}, 32'd1);
    check("ws_dm_rdata", bus.dm_rdata,           32'd0);
    step();
    bus.mem_rvalid = 0; bus.mem_gnt = 1;
    settle();
    check("ws_if_late",  {31'd0, bus.if_ready}, 32'd1);
    check("ws_if_addr",  bus.mem_addr,          32'h8);
    step();
    bus.if_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h11;
    settle();
    check("ws_if_rdata", bus.if_rdata, 32'h11);
    step();
    bus.mem_rvalid = 0;
    settle();
    check("pre_err", {31'd0, bus.err_spurious}, 32'd0);

    // ---------------- spurious response ----------------
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h5;
    settle();
    check("sp_if_rv", {31'd0, bus.if_rvalid}, 32'd0);
    check("sp_dm_rv", {31'd0, bus.dm_rvalid}, 32'd0);
    step();
    bus.mem_rvalid = 0;
    settle();
    check("sp_err", {31'd0, bus.err_spurious}, 32'd1);
    bus.if_req = 1; bus.if_addr = 32'hC; bus.mem_gnt = 1;
    step();
    bus.if_req = 0; bus.mem_gnt = 0;
    settle();
    check("sp_err_hold", {31'd0, bus.err_spurious}, 32'd1);

    // ---------------- reset mid-transaction (arbiter is in WAIT) ----------------
    bus.if_req = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
    rst = 1;
    settle();
    check_all_zero("rst_mid");
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    step();
    bus.mem_rvalid = 0; bus.if_req = 0;
    rst = 0;
    settle();
    bus.if_req = 1; bus.if_addr = 32'h10; bus.mem_gnt = 1;
    settle();
    check("post_rst_rdy",  {31'd0, bus.if_ready}, 32'd1);
    check("post_rst_addr", bus.mem_addr,          32'h10);
    step();
    bus.if_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h22;
    settle();
    check("post_rst_rv",   {31'd0, bus.if_rvalid}, 32'd1);
    check("post_rst_data", bus.if_rdata,           32'h22);
    step();
    bus.mem_rvalid = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
